// File: rtl/quad_enc_gen.sv
// quad_enc_gen: quadrature encoder signal generator driven by signed step/period move commands
//   Clk       in   system clock, posedge
//   reset     in   synchronous, active-low reset
//   CmdValid  in   command present
//   CmdReady  out  command can be accepted (registered)
//   CmdSteps  in   signed edge count, >0 forward, <0 reverse
//   CmdPeriod in   Clk cycles between edges, clamped up to MIN_PERIOD
//   Abort     in   stop current command / block acceptance
//   SigA/SigB out  quadrature pair (registered)
//   Busy      out  command in progress
//   Done      out  one-cycle completion pulse
//   Position  out  running signed edge count, wraps
module quad_enc_gen #(
  parameter int CNT_W      = 16,
  parameter int PER_W      = 16,
  parameter int POS_W      = 32,
  parameter int MIN_PERIOD = 2
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    CmdValid,
  output logic                    CmdReady,
  input  logic signed [CNT_W-1:0] CmdSteps,
  input  logic [PER_W-1:0]        CmdPeriod,
  input  logic                    Abort,
  output logic                    SigA,
  output logic                    SigB,
  output logic                    Busy,
  output logic                    Done,
  output logic signed [POS_W-1:0] Position
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               a_q, a_d, b_q, b_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic [PER_W-1:0]   tmr_q, tmr_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [PER_W-1:0]   p;
  logic               accept;
  assign accept   = CmdValid & ready_q & ~Abort;
  assign p        = (CmdPeriod < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : CmdPeriod;
  assign CmdReady = ready_q;
  assign Busy     = (state_q == RUN);
  assign Done     = done_q;
  assign SigA     = a_q;
  assign SigB     = b_q;
  assign Position = pos_q;
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    per_d   = per_q;
    tmr_d   = tmr_q;
    pos_d   = pos_q;
    if (state_q == IDLE) begin
      if (accept && CmdSteps == '0) begin
        done_d = 1'b1;
      end else if (accept) begin
        state_d = RUN;
        ready_d = 1'b0;
        // unsigned magnitude, so the most negative count still yields 2^(CNT_W-1)
        rem_d   = CmdSteps[CNT_W-1] ? -CmdSteps : CmdSteps;
        dir_d   = ~CmdSteps[CNT_W-1];
        per_d   = p;
        tmr_d   = p - PER_W'(1);
      end
    end else if (Abort) begin
      state_d = IDLE;
      ready_d = 1'b1;
    end else if (tmr_q == '0) begin
      // forward 00->10->11->01, reverse is the mirror; one channel flips per edge
      a_d   = dir_q ? ~b_q : b_q;
      b_d   = dir_q ? a_q : ~a_q;
      pos_d = pos_q + (dir_q ? POS_W'(1) : '1);
      rem_d = rem_q - CNT_W'(1);
      tmr_d = per_q - PER_W'(1);
      if (rem_q == CNT_W'(1)) begin
        state_d = IDLE;
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
    end else begin
      tmr_d = tmr_q - PER_W'(1);
    end
  end
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      per_q   <= '0;
      tmr_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
      tmr_q   <= tmr_d;
      pos_q   <= pos_d;
    end
  end
endmodule
